multicore_out_merger: RTL and testbench

Downstream collection stage for the `multicore` array. It captures each core's 28-bit signed result whenever that core's 4-bit `out_en` equals 1. It merges all results into a single ready/valid stream ordered by lowest pending core index, and buffers them in an output FIFO. It replaces per-core file dumping with one hardware-consumable stream for the next processing stage or host interface.

---
 rtl/multicore_pkg.sv | 10 +
 rtl/multicore_out_fifo.sv | 38 +++
 rtl/multicore_out_merger.sv | 71 +++++++
 tb/tb_multicore_out_merger.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// multicore_pkg: shared constants for the multicore array, its result merger and testbenches
// Provides core count, result/enable widths, the active out_en encoding and the core index width.
package multicore_pkg;
   localparam int N_CORES = 35;
   localparam int DATA_W = 28;
   localparam int EN_W = 4;
   localparam int CORE_IDX_W = $clog2(N_CORES);
   localparam int FIFO_DEPTH = 64;
   localparam logic [EN_W-1:0] EN_ACTIVE = 4'd1;
endpackage

// File: rtl/multicore_out_fifo.sv
// multicore_out_fifo: single-clock show-ahead FIFO with occupancy count
// clk, rst (async, active-high); push/din write; pop consumes head;
// dout is the head (zero when empty), valid = non-empty, full, count = occupancy.
module multicore_out_fifo #(
   parameter int W = 34,
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic                       valid,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   assign valid = count != '0;
   assign full = count == CW'(DEPTH);
   // gating the head keeps the output at zero through reset and while empty
   assign dout = valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/multicore_out_merger.sv
// multicore_out_merger: captures per-core results and merges them into one ready/valid stream
// clk, rst (async, active-high); core_out/core_en flattened per-core results and out_en fields;
// out_data/out_core/out_valid/out_ready head-of-FIFO stream; fifo_count occupancy;
// overflow sticky flag for a result overwritten in its hold register before being merged.
module multicore_out_merger import multicore_pkg::*; #(
   parameter int N_CORES = multicore_pkg::N_CORES,
   parameter int DATA_W = multicore_pkg::DATA_W,
   parameter int EN_W = multicore_pkg::EN_W,
   parameter int DEPTH = multicore_pkg::FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_CORES*DATA_W-1:0]     core_out,
   input  logic [N_CORES*EN_W-1:0]       core_en,
   output logic signed [DATA_W-1:0]      out_data,
   output logic [$clog2(N_CORES)-1:0]    out_core,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(DEPTH+1)-1:0]    fifo_count,
   output logic                          overflow
);
   localparam int IW = $clog2(N_CORES);
   localparam int W = DATA_W + IW;
   logic [DATA_W-1:0] hold_data [N_CORES];
   logic [N_CORES-1:0] hold_pend, hit, drain;
   logic [IW-1:0] sel;
   logic found, push, pop, full;
   logic [W-1:0] dout;
   always_comb begin
      hit = '0;
      for (int i = 0; i < N_CORES; i++) hit[i] = core_en[i*EN_W +: EN_W] == EN_W'(EN_ACTIVE);
   end
   // scanning downward leaves the lowest pending index selected
   always_comb begin
      sel = '0;
      found = 1'b0;
      for (int i = N_CORES-1; i >= 0; i--)
         if (hold_pend[i]) begin
            sel = IW'(i);
            found = 1'b1;
         end
   end
   assign pop = out_valid && out_ready;
   assign push = found && (!full || pop);
   assign drain = push ? N_CORES'(1) << sel : '0;
   // a fresh capture on the drain cycle re-arms the hold; only an undrained pending hold is lost
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hold_pend <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < N_CORES; i++) hold_data[i] <= '0;
      end else begin
         hold_pend <= hit | (hold_pend & ~drain);
         overflow <= overflow | (|(hit & hold_pend & ~drain));
         for (int i = 0; i < N_CORES; i++)
            if (hit[i]) hold_data[i] <= core_out[i*DATA_W +: DATA_W];
      end
   multicore_out_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .din({sel, hold_data[sel]}),
      .dout(dout),
      .valid(out_valid),
      .full(full),
      .count(fifo_count)
   );
   assign out_core = dout[W-1 -: IW];
   assign out_data = dout[DATA_W-1:0];
endmodule

// File: tb/tb_multicore_out_merger.sv
// tb_multicore_out_merger: scoreboard bench for the multicore result merger
module tb_multicore_out_merger;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [35*28-1:0] core_out = '0;
   logic [35*4-1:0] core_en = '0;
   logic signed [27:0] out_data;
   logic [5:0] out_core;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [6:0] fifo_count;
   logic overflow;
   int total = 0;
   int bad = 0;
   logic [33:0] exp_q [$];
   localparam logic [34:0] ALL = {35{1'b1}};

   multicore_out_merger dut (
      .clk(clk),
      .rst(rst),
      .core_out(core_out),
      .core_en(core_en),
      .out_data(out_data),
      .out_core(out_core),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .fifo_count(fifo_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst && out_valid && out_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL stream_extra got core=%0d data=%0d required nothing", out_core, out_data);
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            if ({out_core, out_data} !== e) begin
               bad++;
               $display("FAIL stream got core=%0d data=%0d required core=%0d data=%0d",
                        out_core, out_data, e[33:28], $signed(e[27:0]));
            end
         end
      end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fire(input logic [34:0] mask, input int base);
      for (int i = 0; i < 35; i++)
         if (mask[i]) begin
            core_en[i*4 +: 4] = 4'd1;
            core_out[i*28 +: 28] = 28'(base - i*1000);
            exp_q.push_back({6'(i), 28'(base - i*1000)});
         end
      cyc(1);
      core_en = '0;
   endtask

   task automatic fire1(input int idx, input int val, input bit track);
      core_en[idx*4 +: 4] = 4'd1;
      core_out[idx*28 +: 28] = 28'(val);
      if (track) exp_q.push_back({6'(idx), 28'(val)});
      cyc(1);
      core_en = '0;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      cyc(3);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_core", 32'(out_core), 0);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_ovf", 32'(overflow), 0);
      rst = 1'b0;
      cyc(1);
      // single core latency
      fire1(7, -12345, 1);
      chk("lat_T_valid", 32'(out_valid), 0);
      cyc(1);
      chk("lat_T1_valid", 32'(out_valid), 1);
      chk("single_data", 32'(out_data), 32'(28'(-12345)));
      chk("single_core", 32'(out_core), 7);
      chk("single_count", 32'(fifo_count), 1);
      chk("single_ovf", 32'(overflow), 0);
      out_ready = 1'b1;
      cyc(2);
      chk("single_empty", 32'(exp_q.size()), 0);
      // burst of 34, 0, 17
      fire((35'd1 << 34) | (35'd1 << 17) | 35'd1, 777);
      cyc(1);
      chk("burst_c0", 32'(out_core), 0);
      cyc(1);
      chk("burst_c17", 32'(out_core), 17);
      cyc(1);
      chk("burst_c34", 32'(out_core), 34);
      cyc(1);
      chk("burst_end_valid", 32'(out_valid), 0);
      // idle encodings
      core_out = '1;
      core_en[1*4 +: 4] = 4'd2;
      core_en[2*4 +: 4] = 4'd15;
      core_en[3*4 +: 4] = 4'd0;
      cyc(1);
      core_en = '0;
      cyc(4);
      chk("idle_valid", 32'(out_valid), 0);
      // all cores at once
      fire(ALL, -20000);
      cyc(40);
      chk("all35_empty", 32'(exp_q.size()), 0);
      chk("all35_valid", 32'(out_valid), 0);
      // refill on drain cycle
      fire1(5, 555, 1);
      fire1(5, 666, 1);
      cyc(4);
      chk("refill_ovf", 32'(overflow), 0);
      chk("refill_empty", 32'(exp_q.size()), 0);
      // backpressure with 70 results
      out_ready = 1'b0;
      fire(ALL, 1000);
      cyc(36);
      fire(ALL, 50000);
      cyc(40);
      chk("bp_count", 32'(fifo_count), 64);
      chk("bp_ovf", 32'(overflow), 0);
      out_ready = 1'b1;
      cyc(100);
      chk("bp_empty", 32'(exp_q.size()), 0);
      chk("bp_count_end", 32'(fifo_count), 0);
      // collision under full stall
      out_ready = 1'b0;
      fire(ALL, -7000);
      cyc(36);
      fire(35'h1FFF_FFFF, 3000);
      cyc(31);
      chk("col_count", 32'(fifo_count), 64);
      fire1(3, 100, 0);
      fire1(3, 200, 1);
      cyc(1);
      chk("col_ovf", 32'(overflow), 1);
      chk("col_count_hold", 32'(fifo_count), 64);
      out_ready = 1'b1;
      cyc(100);
      chk("col_empty", 32'(exp_q.size()), 0);
      // async reset mid-stream
      out_ready = 1'b0;
      fire(35'h3FF, 9000);
      cyc(12);
      chk("ar_count_pre", 32'(fifo_count), 10);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid", 32'(out_valid), 0);
      chk("ar_count", 32'(fifo_count), 0);
      chk("ar_ovf", 32'(overflow), 0);
      chk("ar_data", 32'(out_data), 0);
      exp_q.delete();
      cyc(2);
      rst = 1'b0;
      out_ready = 1'b1;
      cyc(5);
      chk("ar_no_stale", 32'(out_valid), 0);
      fire1(20, -1, 1);
      cyc(4);
      chk("ar_post_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
